// File: rtl/overlay_compositor.sv
// Text-overlay compositor: shadow/scroll coordinate generation, blink and
// scroll frame counters, and priority merge of per-layer main/shadow hits.
//
// Ports:
//   clk, rst            pixel clock, synchronous active-high reset
//   x, y                current pixel position
//   frame_active        visible-area qualifier
//   frame_start         one-cycle pulse at the start of each frame
//   pause               freezes the blink and scroll counters
//   layer_en            per-layer enable
//   main_hit            generator hits at the main coordinates
//   shadow_hit          generator hits at the shadow coordinates
//   x_shadow, y_shadow  shadow coordinates (combinational)
//   x_scroll            scrolled main x (combinational)
//   x_scroll_sh         scrolled shadow x (combinational)
//   text_active         registered: a visible layer has a main hit
//   overlay_active      registered: text or shadow
//   shadow_only         registered: shadow without text
//   layer_idx           registered: winning layer index
//   blink_on            current blink phase
module overlay_compositor #(
    parameter int N_LAYERS     = 3,
    parameter int SHADOW_DX    = 4,
    parameter int SHADOW_DY    = 4,
    parameter int H_WRAP       = 640,
    parameter int SCROLL_STEP  = 1,
    parameter int SCROLL_DIV   = 2,
    parameter int BLINK_FRAMES = 30,
    parameter logic [N_LAYERS-1:0] BLINK_LAYERS = '0,
    localparam int LW = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [9:0]          x,
    input  logic [9:0]          y,
    input  logic                frame_active,
    input  logic                frame_start,
    input  logic                pause,
    input  logic [N_LAYERS-1:0] layer_en,
    input  logic [N_LAYERS-1:0] main_hit,
    input  logic [N_LAYERS-1:0] shadow_hit,
    output logic [9:0]          x_shadow,
    output logic [9:0]          y_shadow,
    output logic [9:0]          x_scroll,
    output logic [9:0]          x_scroll_sh,
    output logic                text_active,
    output logic                overlay_active,
    output logic                shadow_only,
    output logic [LW-1:0]       layer_idx,
    output logic                blink_on
);

    localparam int FW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [FW-1:0] FRAME_LAST = FW'(SCROLL_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
    localparam logic [10:0]   WRAP11     = 11'(H_WRAP);
    localparam logic [10:0]   STEP11     = 11'(SCROLL_STEP);

    logic [9:0]    scroll_off;
    logic [FW-1:0] frame_cnt;
    logic [BW-1:0] blink_cnt;

    logic          tick;
    logic [10:0]   scroll_sum;
    logic [9:0]    scroll_next;

    logic [N_LAYERS-1:0] vis;
    logic [N_LAYERS-1:0] m;
    logic [N_LAYERS-1:0] s;
    logic                m_any;
    logic                s_any;
    logic [LW-1:0]       m_idx;
    logic [LW-1:0]       s_idx;
    logic [LW-1:0]       win_idx;

    // Single fold back into [0,H_WRAP); inputs are assumed in range.
    function automatic logic [9:0] fold(input logic [9:0] c,
                                        input logic [9:0] off);
        logic [10:0] sum;
        sum = {1'b0, c} + {1'b0, off};
        if (sum >= WRAP11) begin
            sum = sum - WRAP11;
        end
        return sum[9:0];
    endfunction

    assign x_shadow    = x - 10'(SHADOW_DX);
    assign y_shadow    = y - 10'(SHADOW_DY);
    assign x_scroll    = fold(x, scroll_off);
    assign x_scroll_sh = fold(x_shadow, scroll_off);

    // Pause wins over a coincident frame_start.
    assign tick = frame_start & ~pause;

    always_comb begin
        scroll_sum  = {1'b0, scroll_off} + STEP11;
        scroll_next = scroll_sum[9:0];
        if (scroll_sum >= WRAP11) begin
            scroll_next = 10'(scroll_sum - WRAP11);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scroll_off <= '0;
            frame_cnt  <= '0;
            blink_cnt  <= '0;
            blink_on   <= 1'b1;
        end else if (tick) begin
            if (frame_cnt == FRAME_LAST) begin
                frame_cnt  <= '0;
                scroll_off <= scroll_next;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        vis = layer_en & (~BLINK_LAYERS | {N_LAYERS{blink_on}});
        m   = main_hit & vis;
        s   = shadow_hit & vis;
    end

    assign m_any = |m;
    assign s_any = |s;

    // Scan downward so the lowest set index is the one left standing.
    always_comb begin
        m_idx = '0;
        s_idx = '0;
        for (int i = N_LAYERS - 1; i >= 0; i--) begin
            if (m[i]) begin
                m_idx = LW'(i);
            end
            if (s[i]) begin
                s_idx = LW'(i);
            end
        end
    end

    // Any main hit beats every shadow, even a higher-priority layer's.
    always_comb begin
        win_idx = '0;
        if (frame_active) begin
            if (m_any) begin
                win_idx = m_idx;
            end else if (s_any) begin
                win_idx = s_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            text_active    <= 1'b0;
            overlay_active <= 1'b0;
            shadow_only    <= 1'b0;
            layer_idx      <= '0;
        end else begin
            text_active    <= frame_active & m_any;
            overlay_active <= frame_active & (m_any | s_any);
            shadow_only    <= frame_active & ~m_any & s_any;
            layer_idx      <= win_idx;
        end
    end

endmodule

// File: tb/tb_overlay_compositor.sv
// Bench for overlay_compositor: directed steps then randomized traffic,
// checked against a frame-count based reference model.
module tb_overlay_compositor;

    localparam int N  = 3;
    localparam int DX = 4;
    localparam int DY = 4;
    localparam int HW = 640;
    localparam int ST = 1;
    localparam int SD = 2;
    localparam int BF = 30;
    localparam logic [2:0] BL = 3'b001;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] x, y;
    logic       frame_active, frame_start, pause;
    logic [2:0] layer_en, main_hit, shadow_hit;
    logic [9:0] x_shadow, y_shadow, x_scroll, x_scroll_sh;
    logic       text_active, overlay_active, shadow_only, blink_on;
    logic [1:0] layer_idx;

    int checks = 0;
    int errors = 0;
    int frames = 0;

    overlay_compositor #(
        .N_LAYERS(N), .SHADOW_DX(DX), .SHADOW_DY(DY), .H_WRAP(HW),
        .SCROLL_STEP(ST), .SCROLL_DIV(SD), .BLINK_FRAMES(BF),
        .BLINK_LAYERS(BL)
    ) dut (
        .clk(clk), .rst(rst), .x(x), .y(y),
        .frame_active(frame_active), .frame_start(frame_start),
        .pause(pause), .layer_en(layer_en), .main_hit(main_hit),
        .shadow_hit(shadow_hit), .x_shadow(x_shadow),
        .y_shadow(y_shadow), .x_scroll(x_scroll),
        .x_scroll_sh(x_scroll_sh), .text_active(text_active),
        .overlay_active(overlay_active), .shadow_only(shadow_only),
        .layer_idx(layer_idx), .blink_on(blink_on)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int m_scroll();
        return ((frames / SD) * ST) % HW;
    endfunction

    function automatic logic m_blink();
        return ((frames / BF) % 2) == 0;
    endfunction

    function automatic int scr(input int c);
        int v;
        v = c + m_scroll();
        if (v >= HW) v = v - HW;
        return v % 1024;
    endfunction

    task automatic chk_comb();
        chk("x_shadow", x_shadow, (x + 1024 - DX) % 1024);
        chk("y_shadow", y_shadow, (y + 1024 - DY) % 1024);
        chk("x_scroll", x_scroll, scr(x));
        chk("x_scroll_sh", x_scroll_sh, scr((x + 1024 - DX) % 1024));
        chk("blink_on", blink_on, m_blink());
    endtask

    // Apply current inputs across one edge and check the result.
    task automatic cycle();
        logic t, o, so;
        int idx, mi, si;
        logic b;
        b  = m_blink();
        mi = -1;
        si = -1;
        for (int i = 0; i < N; i++) begin
            if (layer_en[i] && (!BL[i] || b)) begin
                if (main_hit[i] && mi < 0) mi = i;
                if (shadow_hit[i] && si < 0) si = i;
            end
        end
        t   = frame_active && mi >= 0;
        o   = frame_active && (mi >= 0 || si >= 0);
        so  = frame_active && mi < 0 && si >= 0;
        idx = !frame_active ? 0 : (mi >= 0 ? mi : (si >= 0 ? si : 0));
        if (rst) begin
            t = 0; o = 0; so = 0; idx = 0;
            frames = 0;
        end else if (frame_start && !pause) begin
            frames++;
        end
        @(posedge clk);
        #1;
        chk("text_active", text_active, t);
        chk("overlay_active", overlay_active, o);
        chk("shadow_only", shadow_only, so);
        chk("layer_idx", layer_idx, idx);
        chk_comb();
    endtask

    task automatic pulse(input logic p);
        frame_start = 1'b1;
        pause = p;
        cycle();
        frame_start = 1'b0;
        pause = 1'b0;
        cycle();
    endtask

    initial begin
        rst = 1'b1; x = 10; y = 10;
        frame_active = 0; frame_start = 0; pause = 0;
        layer_en = 3'b000; main_hit = 0; shadow_hit = 0;
        cycle();
        cycle();
        chk("rst_text", text_active, 0);
        chk("rst_overlay", overlay_active, 0);
        chk("rst_idx", layer_idx, 0);
        chk("rst_blink", blink_on, 1);
        chk("rst_scroll", x_scroll, 10);

        rst = 0; frame_active = 1; layer_en = 3'b111;
        main_hit = 3'b110; shadow_hit = 3'b001;
        cycle();
        chk("d_text", text_active, 1);
        chk("d_overlay", overlay_active, 1);
        chk("d_shonly", shadow_only, 0);
        chk("d_idx1", layer_idx, 1);

        main_hit = 0; shadow_hit = 3'b100;
        cycle();
        chk("d_sh_overlay", overlay_active, 1);
        chk("d_sh_text", text_active, 0);
        chk("d_sh_only", shadow_only, 1);
        chk("d_idx2", layer_idx, 2);

        frame_active = 0;
        cycle();
        chk("d_fa0_overlay", overlay_active, 0);
        chk("d_fa0_idx", layer_idx, 0);

        x = 0; y = 2;
        #1;
        chk("d_xsh", x_shadow, 1020);
        chk("d_ysh", y_shadow, 1022);

        for (int i = 0; i < 8; i++) pulse(1'b0);
        x = 638;
        #1;
        chk("d_scroll4", x_scroll, 2);

        pulse(1'b1);
        chk("d_pause", x_scroll, 2);

        for (int i = 0; i < 22; i++) pulse(1'b0);
        chk("d_blink0", blink_on, 0);
        frame_active = 1; main_hit = 3'b001; shadow_hit = 0;
        cycle();
        chk("d_blink_text", text_active, 0);

        rst = 1;
        cycle();
        chk("d_rst_blink", blink_on, 1);
        chk("d_rst_text", text_active, 0);
        chk("d_rst_scroll", x_scroll, 638);
        rst = 0;

        for (int i = 0; i < 3000; i++) begin
            rst          = ($urandom_range(0, 199) == 0);
            x            = 10'($urandom_range(0, HW - 1));
            y            = 10'($urandom_range(0, 479));
            frame_active = ($urandom_range(0, 3) != 0);
            frame_start  = ($urandom_range(0, 3) == 0);
            pause        = ($urandom_range(0, 4) == 0);
            layer_en     = 3'($urandom);
            main_hit     = 3'($urandom);
            shadow_hit   = 3'($urandom);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
